// File: rtl/sound_pkg.sv
// Shared types and default widths for the sound note sequencer family.
// Note table entries are packed {last, rest, dur, div}, MSB first.
package sound_pkg;

   localparam int SND_ADDR_W  = 6;
   localparam int SND_DIV_W   = 18;
   localparam int SND_DUR_W   = 10;
   localparam int SND_ENTRY_W = 2 + SND_DUR_W + SND_DIV_W;

   typedef struct packed {
      logic                 last;
      logic                 rest;
      logic [SND_DUR_W-1:0] dur;
      logic [SND_DIV_W-1:0] div;
   } note_entry_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_WAIT,
      S_PLAY,
      S_GAP,
      S_DONE
   } seq_state_t;

endpackage

// File: rtl/sound_tick_gen.sv
// Clearable prescaler: counts 0..tc_i and pulses tick_o on the terminal count.
// Shared by the timed sound blocks.
module sound_tick_gen #(
   parameter int W = 4
) (
   input  logic         clk_i,
   input  logic         rstn_i,
   input  logic         clr_i,
   input  logic [W-1:0] tc_i,
   output logic         tick_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   assign tick_o = !clr_i && (cnt_q == tc_i);

   always_comb begin
      cnt_d = cnt_q + W'(1);
      if (clr_i || (cnt_q == tc_i)) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/sound_note_sequencer.sv
// Steps a note table in a synchronous ROM, driving tone divider and gate.
// Optional SOUND_SEQ_TEMPO_EN adds tempo_shift (ticks = TPT >> shift).
module sound_note_sequencer
   import sound_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int TICK_HZ   = 1000,
   parameter int ADDR_W    = SND_ADDR_W,
   parameter int DIV_W     = SND_DIV_W,
   parameter int DUR_W     = SND_DUR_W,
   parameter int GAP_TICKS = 20
) (
   input  logic                    clk,
   input  logic                    rstn,
   input  logic                    en,
   input  logic                    loop,
`ifdef SOUND_SEQ_TEMPO_EN
   input  logic [1:0]              tempo_shift,
`endif
   output logic [ADDR_W-1:0]       rom_addr,
   output logic                    rom_rd,
   input  logic [2+DUR_W+DIV_W-1:0] rom_data,
   output logic [DIV_W-1:0]        tone_div,
   output logic                    tone_on,
   output logic                    busy,
   output logic                    done
);

   localparam int TPT = CLK_HZ / TICK_HZ;
   localparam int TW  = (TPT > 2) ? $clog2(TPT) : 1;
   localparam int GW  = $clog2(GAP_TICKS + 1);
   localparam int RW  = (GW > DUR_W) ? GW : DUR_W;
   localparam logic [31:0] TPT_W = 32'(TPT);

   generate
      if (TPT < 2) begin : g_tpt_chk
         $error("sound_note_sequencer: CLK_HZ/TICK_HZ must be >= 2");
      end
   endgenerate

   seq_state_t        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [RW-1:0]     rem_q, rem_d;
   logic [TW-1:0]     tc_q, tc_d;
   logic              rd_q, rd_d;
   logic              on_q, on_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              e_last;
   logic              e_rest;
   logic [DUR_W-1:0]  e_dur;
   logic [DIV_W-1:0]  e_div;

   logic [1:0]        shift;
   logic [31:0]       eff;
   logic [TW-1:0]     tc_eff;
   logic              clr;
   logic              tick;

   assign {e_last, e_rest, e_dur, e_div} = rom_data;

`ifdef SOUND_SEQ_TEMPO_EN
   assign shift = tempo_shift;
`else
   assign shift = 2'd0;
`endif

   // Very short phases degrade to one cycle per tick.
   assign eff    = TPT_W >> shift;
   assign tc_eff = (eff < 32'd2) ? '0 : TW'(eff - 32'd1);

   assign clr = !((state_q == S_PLAY) || (state_q == S_GAP));

   sound_tick_gen #(
      .W (TW)
   ) u_tick (
      .clk_i  (clk),
      .rstn_i (rstn),
      .clr_i  (clr),
      .tc_i   (tc_q),
      .tick_o (tick)
   );

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         tc_q    <= '0;
         rd_q    <= 1'b0;
         on_q    <= 1'b0;
         div_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         tc_q    <= tc_d;
         rd_q    <= rd_d;
         on_q    <= on_d;
         div_q   <= div_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      tc_d    = tc_q;
      if (!en) begin
         state_d = S_IDLE;
         addr_d  = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               state_d = S_FETCH;
               addr_d  = '0;
            end
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
               if (e_last && loop) begin
                  state_d = S_FETCH;
                  addr_d  = '0;
               end else if (e_last) begin
                  state_d = S_DONE;
               end else if (e_dur == '0) begin
                  state_d = S_FETCH;
                  addr_d  = addr_q + ADDR_W'(1);
               end else begin
                  state_d = S_PLAY;
                  rem_d   = RW'(e_dur);
                  tc_d    = tc_eff;
               end
            end
            S_PLAY: begin
               if (tick) begin
                  if (rem_q != RW'(1)) begin
                     rem_d = rem_q - RW'(1);
                  end else if (GAP_TICKS > 0) begin
                     state_d = S_GAP;
                     rem_d   = RW'(GAP_TICKS);
                     tc_d    = tc_eff;
                  end else begin
                     state_d = S_FETCH;
                     addr_d  = addr_q + ADDR_W'(1);
                  end
               end
            end
            S_GAP: begin
               if (tick) begin
                  if (rem_q != RW'(1)) begin
                     rem_d = rem_q - RW'(1);
                  end else begin
                     state_d = S_FETCH;
                     addr_d  = addr_q + ADDR_W'(1);
                  end
               end
            end
            S_DONE: state_d = S_DONE;
            default: begin
               state_d = S_IDLE;
               addr_d  = '0;
            end
         endcase
      end
   end

   // Registered outputs follow the state being entered.
   always_comb begin
      rd_d   = (state_d == S_FETCH);
      busy_d = !((state_d == S_IDLE) || (state_d == S_DONE));
      done_d = (state_d == S_DONE);
      div_d  = div_q;
      on_d   = 1'b0;
      if (state_d == S_PLAY) begin
         on_d = (state_q == S_WAIT) ? !e_rest : on_q;
      end
      if ((state_q == S_WAIT) && (state_d == S_PLAY)) begin
         div_d = e_div;
      end
   end

   assign rom_addr = addr_q;
   assign rom_rd   = rd_q;
   assign tone_div = div_q;
   assign tone_on  = on_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule

// File: tb/tb_sound_note_sequencer.sv
// Scoreboard bench: a timeline model of the melody fills a queue of
// expected per-cycle outputs; a monitor pops and compares each cycle.
module tb_sound_note_sequencer;
   import sound_pkg::*;

   localparam int CLK_HZ    = 1000;
   localparam int TICK_HZ   = 100;
   localparam int GAP_TICKS = 2;
   localparam int TPT       = CLK_HZ / TICK_HZ;
   localparam int AW        = SND_ADDR_W;
   localparam int DW        = SND_DIV_W;
   localparam int EW        = SND_ENTRY_W;
   localparam int DEPTH     = 1 << AW;

   typedef struct packed {
      logic          rd;
      logic [AW-1:0] addr;
      logic          on;
      logic [DW-1:0] div;
      logic          busy;
      logic          done;
   } obs_t;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic          en = 1'b0;
   logic          loop = 1'b0;
   logic [1:0]    tempo_shift = 2'd0;
   logic [AW-1:0] rom_addr;
   logic          rom_rd;
   logic [EW-1:0] rom_data = '0;
   logic [DW-1:0] tone_div;
   logic          tone_on;
   logic          busy;
   logic          done;

   logic [EW-1:0] rom [DEPTH];
   obs_t          exp_q[$];
   obs_t          mon_e, mon_a;
   logic [DW-1:0] cur_div = '0;
   string         phase = "reset";
   int            n_checks = 0;
   int            n_fail = 0;

   sound_note_sequencer #(
      .CLK_HZ    (CLK_HZ),
      .TICK_HZ   (TICK_HZ),
      .GAP_TICKS (GAP_TICKS)
   ) dut (
      .clk         (clk),
      .rstn        (rstn),
      .en          (en),
      .loop        (loop),
`ifdef SOUND_SEQ_TEMPO_EN
      .tempo_shift (tempo_shift),
`endif
      .rom_addr    (rom_addr),
      .rom_rd      (rom_rd),
      .rom_data    (rom_data),
      .tone_div    (tone_div),
      .tone_on     (tone_on),
      .busy        (busy),
      .done        (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rom_rd) rom_data <= rom[rom_addr];
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = '{rom_rd, rom_addr, tone_on, tone_div, busy, done};
            n_checks++;
            if (mon_a !== mon_e) begin
               n_fail++;
               $display("FAIL %s @%0t got rd=%0b addr=%0d on=%0b div=%0d busy=%0b done=%0b want rd=%0b addr=%0d on=%0b div=%0d busy=%0b done=%0b",
                        phase, $time, mon_a.rd, mon_a.addr, mon_a.on, mon_a.div, mon_a.busy, mon_a.done,
                        mon_e.rd, mon_e.addr, mon_e.on, mon_e.div, mon_e.busy, mon_e.done);
            end
         end
      end
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [EW-1:0] mk(input logic l, input logic r,
                                        input int dur, input int div);
      note_entry_t e;
      e.last = l;
      e.rest = r;
      e.dur  = SND_DUR_W'(dur);
      e.div  = DW'(div);
      return e;
   endfunction

   task automatic fill_end();
      for (int i = 0; i < DEPTH; i++) rom[i] = mk(1'b1, 1'b0, 0, 0);
   endtask

   // Expected melody timeline for n cycles after en rises, from address 0.
   task automatic gen_trace(input int n, input int shift);
      obs_t          t[$];
      note_entry_t   ent;
      int            a;
      int            eff;
      logic [DW-1:0] d;
      a   = 0;
      d   = cur_div;
      eff = TPT >> shift;
      if (eff < 1) eff = 1;
      while (t.size() < n) begin
         t.push_back('{1'b1, AW'(a), 1'b0, d, 1'b1, 1'b0});
         t.push_back('{1'b0, AW'(a), 1'b0, d, 1'b1, 1'b0});
         ent = note_entry_t'(rom[a]);
         if (ent.last && loop) begin
            a = 0;
         end else if (ent.last) begin
            while (t.size() < n) t.push_back('{1'b0, AW'(a), 1'b0, d, 1'b0, 1'b1});
         end else if (ent.dur == 0) begin
            a = (a + 1) % DEPTH;
         end else begin
            d = ent.div;
            repeat (int'(ent.dur) * eff) t.push_back('{1'b0, AW'(a), !ent.rest, d, 1'b1, 1'b0});
            repeat (GAP_TICKS * eff) t.push_back('{1'b0, AW'(a), 1'b0, d, 1'b1, 1'b0});
            a = (a + 1) % DEPTH;
         end
      end
      while (t.size() > n) void'(t.pop_back());
      cur_div = t[n-1].div;
      foreach (t[i]) exp_q.push_back(t[i]);
   endtask

   task automatic play(input string name, input int n, input int shift);
      phase       = name;
      tempo_shift = 2'(shift);
      en          = 1'b1;
      gen_trace(n, shift);
      repeat (n) @(negedge clk);
   endtask

   task automatic stop(input int m);
      en = 1'b0;
      repeat (m) exp_q.push_back('{1'b0, '0, 1'b0, cur_div, 1'b0, 1'b0});
      repeat (m) @(negedge clk);
   endtask

   task automatic reset_pulse(input int m, input logic en_v, input logic loop_v);
      rstn    = 1'b0;
      en      = en_v;
      loop    = loop_v;
      cur_div = '0;
      repeat (m) exp_q.push_back('0);
      repeat (m) @(negedge clk);
      rstn = 1'b1;
      en   = 1'b0;
      repeat (2) exp_q.push_back('0);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int max_shift;
      max_shift = 0;
`ifdef SOUND_SEQ_TEMPO_EN
      max_shift = 3;
`endif
      fill_end();
      @(negedge clk);
      phase = "reset";
      reset_pulse(3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      fill_end();
      rom[0] = mk(1'b0, 1'b0, 3, 1000);
      loop   = 1'b0;
      play("single_note", 60, 0);
      stop(2);

      fill_end();
      rom[0] = mk(1'b0, 1'b1, 2, 500);
      rom[1] = mk(1'b0, 1'b0, 0, 700);
      rom[2] = mk(1'b0, 1'b0, 1, 300);
      play("rest_skip", 85, 0);
      stop(2);

      fill_end();
      rom[0] = mk(1'b0, 1'b0, 3, 1000);
      loop   = 1'b1;
      play("loop", 3 * 54 + 2, 0);
      stop(2);

      loop = 1'b0;
      play("abort", 17, 0);
      stop(2);
      play("restart", 5, 0);
      stop(2);

`ifdef SOUND_SEQ_TEMPO_EN
      play("tempo", 40, 1);
      stop(2);
`endif

      play("reset_mid", 12, 0);
      phase = "reset_mid";
      reset_pulse(2, 1'b0, 1'b0);

      for (int i = 0; i < DEPTH; i++) rom[i] = mk(1'b0, 1'b0, 0, int'($urandom_range(0, 262143)));
      rom[2]  = mk(1'b0, 1'b0, 1, 55);
      rom[63] = mk(1'b0, 1'b1, 1, 77);
      play("wrap", 2 * 64 + 2 * 30 + 20, 0);
      stop(2);

      for (int it = 0; it < 25; it++) begin
         for (int i = 0; i < DEPTH; i++) begin
            rom[i] = mk(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                        int'($urandom_range(0, 3)), int'($urandom_range(0, 262143)));
         end
         loop = 1'($urandom_range(0, 1));
         play("random", int'($urandom_range(10, 250)), int'($urandom_range(0, max_shift)));
         if ($urandom_range(0, 4) == 0) begin
            reset_pulse(2, 1'b0, loop);
         end else begin
            stop(int'($urandom_range(1, 3)));
         end
      end

      phase = "drain";
      repeat (4) @(negedge clk);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expected samples left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
